// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan driver
package seg7_pkg;

    typedef enum logic {SHOW, GUARD} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment decoder
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed common-anode seven-segment scanner with
// per-digit enables, frame-boundary updates and a dark guard between slots.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [4*NUM_DIGITS-1:0] Data,
    input  logic                    Load,
    input  logic [NUM_DIGITS-1:0]   DigEn,
    output logic [6:0]              out7,
    output logic [NUM_DIGITS-1:0]   en_out,
    output logic                    FrameSync
);

    localparam int DW   = 4 * NUM_DIGITS;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAXC = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic          HAS_GUARD  = (GUARD_CYCLES > 0);

    state_t                  r_state, w_next;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic                    r_started;
    logic [DW-1:0]           r_disp_data, r_pend_data;
    logic [NUM_DIGITS-1:0]   r_disp_en, r_pend_en;
    logic                    r_pend_valid;
    logic [6:0]              r_out7;
    logic [NUM_DIGITS-1:0]   r_en_out;
    logic                    r_fs;

    logic                    w_show_tc, w_guard_tc, w_adv, w_bound, w_xfer;
    logic [IW-1:0]           w_nidx;
    logic [DW-1:0]           w_ddata_n;
    logic [NUM_DIGITS-1:0]   w_den_n;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg;
    logic                    w_lzb;
    logic [6:0]              w_out7_n;
    logic [NUM_DIGITS-1:0]   w_en_n;

    assign w_show_tc  = (r_state == SHOW) && (r_cnt == SHOW_LAST);
    assign w_guard_tc = (r_state == GUARD) && (!HAS_GUARD || r_cnt == GUARD_LAST);
    assign w_adv      = w_guard_tc || (w_show_tc && !HAS_GUARD);
    // The first advance after reset lands on digit 0 rather than digit 1
    assign w_nidx     = (!r_started || r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    assign w_bound    = w_adv && (w_nidx == '0);
    assign w_xfer     = w_bound && r_pend_valid;
    // Display contents as they will be after this edge, so a fresh frame lights its new value at once
    assign w_ddata_n  = w_xfer ? r_pend_data : r_disp_data;
    assign w_den_n    = w_xfer ? r_pend_en : r_disp_en;
    assign w_nib      = w_ddata_n[{w_nidx, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
    assign w_lzb = (w_nidx != '0) && ((w_ddata_n >> {w_nidx, 2'b00}) == '0);
`else
    assign w_lzb = 1'b0;
`endif

    seg7_hex_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    // State register with slot counter and digit index
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= GUARD;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_adv || w_show_tc) ? '0 : r_cnt + 1'b1;
            r_idx     <= w_adv ? w_nidx : r_idx;
            r_started <= r_started | w_adv;
        end
    end

    // Next state: a slot ends in the guard interval when one is configured
    always_comb begin
        w_next = w_adv ? SHOW : (w_show_tc ? GUARD : r_state);
    end

    // Next outputs: light the new digit on slot entry, go dark on guard entry, else hold
    always_comb begin
        w_out7_n = w_adv ? ((w_den_n[w_nidx] && !w_lzb) ? w_seg : SEG_BLANK)
                 : (w_show_tc ? SEG_BLANK : r_out7);
        w_en_n   = w_adv ? (w_den_n[w_nidx] ? ~(NUM_DIGITS'(1) << w_nidx) : '1)
                 : (w_show_tc ? '1 : r_en_out);
    end

    // Registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_out7   <= SEG_BLANK;
            r_en_out <= '1;
            r_fs     <= 1'b0;
        end else begin
            r_out7   <= w_out7_n;
            r_en_out <= w_en_n;
            r_fs     <= w_bound;
        end
    end

    // Pending capture and tear-free transfer; a coincident Load stays pending
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pend_data  <= '0;
            r_pend_en    <= '1;
            r_pend_valid <= 1'b0;
            r_disp_data  <= '0;
            r_disp_en    <= '1;
        end else begin
            if (Load) begin
                r_pend_data  <= Data;
                r_pend_en    <= DigEn;
                r_pend_valid <= 1'b1;
            end else if (w_xfer) begin
                r_pend_valid <= 1'b0;
            end
            if (w_xfer) begin
                r_disp_data <= r_pend_data;
                r_disp_en   <= r_pend_en;
            end
        end
    end

    assign out7      = r_out7;
    assign en_out    = r_en_out;
    assign FrameSync = r_fs;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed bench for seg7_scan_display (4 digits, 4-cycle slots, 2-cycle guard)
module tb_seg7_scan_display;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int GC = 2;
    localparam int FP = N * (SD + GC);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  digen = 4'hF;
    logic [6:0]  out7;
    logic [3:0]  en_out;
    logic        fs;

    int n_chk = 0;
    int n_fail = 0;

    logic [6:0] cap_seg [FP];
    logic [3:0] cap_en  [FP];
    logic       cap_fs  [FP];
    logic [6:0] exp_seg [FP];
    logic [3:0] exp_en  [FP];

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scan_display #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .GUARD_CYCLES (GC)
    ) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .Data      (data),
        .Load      (load),
        .DigEn     (digen),
        .out7      (out7),
        .en_out    (en_out),
        .FrameSync (fs)
    );

    always #5 clk = ~clk;

    // Expected per-cycle outputs of one frame showing word d with enables e
    task automatic build_exp(input logic [15:0] d, input logic [3:0] e);
        for (int t = 0; t < FP; t++) begin
            int k;
            logic lit, blank;
            logic [3:0] nib;
            k = t / (SD + GC);
            lit = (t % (SD + GC)) < SD;
            nib = d[4*k +: 4];
`ifdef SEG7_LZB_EN
            blank = (k > 0) && ((d >> (4 * k)) == 16'h0000);
`else
            blank = 1'b0;
`endif
            exp_en[t]  = (lit && e[k]) ? ~(4'b0001 << k) : 4'hF;
            exp_seg[t] = (lit && e[k] && !blank) ? HEX[nib] : 7'h7F;
        end
    endtask

    // Wait (bounded) for the next frame start and record it, optionally strobing Load at offsets la/lb
    task automatic grab(input int la, input logic [15:0] da, input logic [3:0] ea,
                        input int lb, input logic [15:0] db, input logic [3:0] eb);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!fs && w < 100);
        for (int t = 0; t < FP; t++) begin
            if (t > 0) @(negedge clk);
            cap_seg[t] = out7;
            cap_en[t]  = en_out;
            cap_fs[t]  = fs;
            load = (t == la) || (t == lb);
            if (t == la) begin data = da; digen = ea; end
            if (t == lb) begin data = db; digen = eb; end
        end
    endtask

    task automatic test_reset;
        int c;
        data = 16'h0000; digen = 4'hF;
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (out7 !== 7'h7F) begin n_fail++; $display("FAIL reset_out7 got %h want 7f", out7); end
        n_chk++; if (en_out !== 4'hF) begin n_fail++; $display("FAIL reset_en got %h want f", en_out); end
        n_chk++; if (fs !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b want 0", fs); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (en_out !== 4'hF || fs !== 1'b0) begin n_fail++; $display("FAIL startup_guard got en=%h fs=%b want en=f fs=0", en_out, fs); end
        @(negedge clk);
        n_chk++; if (en_out !== 4'hE || out7 !== 7'h40 || fs !== 1'b1) begin n_fail++; $display("FAIL startup_slot0 got en=%h seg=%h fs=%b want en=e seg=40 fs=1", en_out, out7, fs); end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!fs && c < 100);
        n_chk++; if (c !== FP) begin n_fail++; $display("FAIL frame_period got %0d want %0d", c, FP); end
    endtask

    task automatic test_load_midframe;
        grab(8, 16'h12AF, 4'hF, -1, 16'h0, 4'h0);
        build_exp(16'h0000, 4'hF);
        for (int t = 0; t < FP; t++) begin
            n_chk++; if (cap_en[t] !== exp_en[t] || cap_seg[t] !== exp_seg[t] || cap_fs[t] !== (t == 0)) begin n_fail++; $display("FAIL midframe_cur t=%0d got en=%h seg=%h fs=%b want en=%h seg=%h fs=%b", t, cap_en[t], cap_seg[t], cap_fs[t], exp_en[t], exp_seg[t], t == 0); end
        end
        grab(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        build_exp(16'h12AF, 4'hF);
        for (int t = 0; t < FP; t++) begin
            n_chk++; if (cap_en[t] !== exp_en[t] || cap_seg[t] !== exp_seg[t] || cap_fs[t] !== (t == 0)) begin n_fail++; $display("FAIL midframe_next t=%0d got en=%h seg=%h fs=%b want en=%h seg=%h fs=%b", t, cap_en[t], cap_seg[t], cap_fs[t], exp_en[t], exp_seg[t], t == 0); end
        end
    endtask

    task automatic test_digen;
        grab(3, 16'h12AF, 4'b0101, -1, 16'h0, 4'h0);
        build_exp(16'h12AF, 4'hF);
        for (int t = 0; t < FP; t++) begin
            n_chk++; if (cap_en[t] !== exp_en[t] || cap_seg[t] !== exp_seg[t] || cap_fs[t] !== (t == 0)) begin n_fail++; $display("FAIL digen_cur t=%0d got en=%h seg=%h fs=%b want en=%h seg=%h fs=%b", t, cap_en[t], cap_seg[t], cap_fs[t], exp_en[t], exp_seg[t], t == 0); end
        end
        grab(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        build_exp(16'h12AF, 4'b0101);
        for (int t = 0; t < FP; t++) begin
            n_chk++; if (cap_en[t] !== exp_en[t] || cap_seg[t] !== exp_seg[t] || cap_fs[t] !== (t == 0)) begin n_fail++; $display("FAIL digen_masked t=%0d got en=%h seg=%h fs=%b want en=%h seg=%h fs=%b", t, cap_en[t], cap_seg[t], cap_fs[t], exp_en[t], exp_seg[t], t == 0); end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] words [5];
        logic [3:0]  ens   [5];
        words = '{16'h12AF, 16'h2222, 16'h2222, 16'h4444, 16'h5555};
        ens   = '{4'b0101, 4'hF, 4'hF, 4'hF, 4'hF};
        for (int f = 0; f < 5; f++) begin
            if (f == 0)      grab(2, 16'h1111, 4'hF, 9, 16'h2222, 4'hF);
            else if (f == 2) grab(10, 16'h4444, 4'hF, 23, 16'h5555, 4'hF);
            else             grab(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
            build_exp(words[f], ens[f]);
            for (int t = 0; t < FP; t++) begin
                n_chk++; if (cap_en[t] !== exp_en[t] || cap_seg[t] !== exp_seg[t] || cap_fs[t] !== (t == 0)) begin n_fail++; $display("FAIL b2b f=%0d t=%0d got en=%h seg=%h fs=%b want en=%h seg=%h fs=%b", f, t, cap_en[t], cap_seg[t], cap_fs[t], exp_en[t], exp_seg[t], t == 0); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!fs && w < 100);
        data = 16'h7777; digen = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (out7 !== 7'h7F || en_out !== 4'hF || fs !== 1'b0) begin n_fail++; $display("FAIL midreset_async got seg=%h en=%h fs=%b want seg=7f en=f fs=0", out7, en_out, fs); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (en_out !== 4'hF || out7 !== 7'h7F || fs !== 1'b0) begin n_fail++; $display("FAIL midreset_guard got en=%h seg=%h fs=%b want en=f seg=7f fs=0", en_out, out7, fs); end
        @(negedge clk);
        n_chk++; if (en_out !== 4'hE || out7 !== 7'h40 || fs !== 1'b1) begin n_fail++; $display("FAIL midreset_slot0 got en=%h seg=%h fs=%b want en=e seg=40 fs=1", en_out, out7, fs); end
        grab(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        build_exp(16'h0000, 4'hF);
        for (int t = 0; t < FP; t++) begin
            n_chk++; if (cap_en[t] !== exp_en[t] || cap_seg[t] !== exp_seg[t] || cap_fs[t] !== (t == 0)) begin n_fail++; $display("FAIL midreset_frame t=%0d got en=%h seg=%h fs=%b want en=%h seg=%h fs=%b", t, cap_en[t], cap_seg[t], cap_fs[t], exp_en[t], exp_seg[t], t == 0); end
        end
    endtask

    task automatic test_lzb;
        logic [15:0] words [4];
        words = '{16'h0000, 16'h0050, 16'h0050, 16'h0000};
        for (int f = 0; f < 4; f++) begin
            if (f == 0)      grab(4, 16'h0050, 4'hF, -1, 16'h0, 4'h0);
            else if (f == 2) grab(4, 16'h0000, 4'hF, -1, 16'h0, 4'h0);
            else             grab(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
            build_exp(words[f], 4'hF);
            for (int t = 0; t < FP; t++) begin
                n_chk++; if (cap_en[t] !== exp_en[t] || cap_seg[t] !== exp_seg[t] || cap_fs[t] !== (t == 0)) begin n_fail++; $display("FAIL lzb f=%0d t=%0d got en=%h seg=%h fs=%b want en=%h seg=%h fs=%b", f, t, cap_en[t], cap_seg[t], cap_fs[t], exp_en[t], exp_seg[t], t == 0); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_digen();
        test_back_to_back();
        test_reset_mid();
        test_lzb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
